// File: rtl/tron_pkg.sv
// rtl/tron_pkg.sv - shared types, colour table and heading helpers for the tron motion engine
package tron_pkg;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      LEFT  = 3'd1,
      RIGHT = 3'd2,
      UP    = 3'd3,
      DOWN  = 3'd4
   } dir_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   // Player colours as {red, green, blue}: P0 blue, P1 red, P2 green, P3 yellow.
   localparam logic [23:0] PLAYER_RGB [4] = '{24'h0000FF, 24'hFF0000, 24'h00FF00, 24'hFFFF00};

   function automatic logic is_reverse(input dir_t cur, input dir_t nxt);
      return (cur == LEFT  && nxt == RIGHT) || (cur == RIGHT && nxt == LEFT) ||
             (cur == UP    && nxt == DOWN)  || (cur == DOWN  && nxt == UP);
   endfunction

   // Anything other than exactly one request bit decodes to NONE, which means "hold heading".
   function automatic dir_t onehot_to_dir(input logic [3:0] req);
      case (req)
         4'b0001: return LEFT;
         4'b0010: return RIGHT;
         4'b0100: return UP;
         4'b1000: return DOWN;
         default: return NONE;
      endcase
   endfunction

endpackage

// File: rtl/tron_motion_unit.sv
// rtl/tron_motion_unit.sv - per-player heading register, candidate step and edge policy
module tron_motion_unit
   import tron_pkg::*;
#(
   parameter int COORD_W     = 10,
   parameter int H_RES       = 800,
   parameter int V_RES       = 600,
   parameter int PLAYER_SIZE = 2,
   parameter int STEP        = 1,
   parameter int EDGE_MODE   = 0
) (
   input  logic               clock,
   input  logic               i_clear,
   input  logic               i_run,
   input  logic [3:0]         i_dir,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   output logic [COORD_W-1:0] o_next_x,
   output logic [COORD_W-1:0] o_next_y,
   output logic               o_edge_kill
);

   localparam int SW = COORD_W + 1;
   localparam logic signed [SW-1:0] C_STEP = SW'(STEP);
   localparam logic signed [SW-1:0] C_XMAX = SW'(H_RES - PLAYER_SIZE);
   localparam logic signed [SW-1:0] C_YMAX = SW'(V_RES - PLAYER_SIZE);

   dir_t                   r_head;
   dir_t                   w_req;
   logic signed [SW-1:0]   w_sx;
   logic signed [SW-1:0]   w_sy;
   logic signed [SW-1:0]   w_cx;
   logic signed [SW-1:0]   w_cy;
   logic                   w_x_lo;
   logic                   w_x_hi;
   logic                   w_y_lo;
   logic                   w_y_hi;

   assign w_req = onehot_to_dir(i_dir);

   always_ff @(posedge clock) begin
      if (i_clear) begin
         r_head <= NONE;
      end else if (i_run && w_req != NONE && !is_reverse(r_head, w_req)) begin
         r_head <= w_req;
      end
   end

   assign w_sx = signed'({1'b0, i_x});
   assign w_sy = signed'({1'b0, i_y});

   always_comb begin
      w_cx = w_sx;
      w_cy = w_sy;
      case (r_head)
         LEFT:    w_cx = w_sx - C_STEP;
         RIGHT:   w_cx = w_sx + C_STEP;
         UP:      w_cy = w_sy - C_STEP;
         DOWN:    w_cy = w_sy + C_STEP;
         default: ;
      endcase
   end

   assign w_x_lo = w_cx[SW-1];
   assign w_x_hi = w_cx > C_XMAX;
   assign w_y_lo = w_cy[SW-1];
   assign w_y_hi = w_cy > C_YMAX;

   // Only one axis moves per update, so holding both coordinates on a kill is exact.
   always_comb begin
      o_next_x    = w_cx[COORD_W-1:0];
      o_next_y    = w_cy[COORD_W-1:0];
      o_edge_kill = 1'b0;
      if (EDGE_MODE == 1) begin
         if (w_x_lo)      o_next_x = COORD_W'(H_RES - PLAYER_SIZE);
         else if (w_x_hi) o_next_x = '0;
         if (w_y_lo)      o_next_y = COORD_W'(V_RES - PLAYER_SIZE);
         else if (w_y_hi) o_next_y = '0;
      end else begin
         if (w_x_lo || w_x_hi) o_next_x = i_x;
         if (w_y_lo || w_y_hi) o_next_y = i_y;
         if (EDGE_MODE == 2)   o_edge_kill = w_x_lo || w_x_hi || w_y_lo || w_y_hi;
      end
   end

endmodule

// File: rtl/tron_motion_engine.sv
// rtl/tron_motion_engine.sv - N-player motion, collision, round FSM and registered pixel colour
module tron_motion_engine
   import tron_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int COORD_W     = 10,
   parameter int H_RES       = 800,
   parameter int V_RES       = 600,
   parameter int PLAYER_SIZE = 2,
   parameter int STEP        = 1,
   parameter int FRAME_DIV   = 1,
   parameter int EDGE_MODE   = 0,
   parameter logic [COORD_W*NUM_PLAYERS-1:0] START_X = {10'd775, 10'd16},
   parameter logic [COORD_W*NUM_PLAYERS-1:0] START_Y = {10'd16, 10'd575}
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             i_dflt,
   input  logic                             i_start,
   input  logic [COORD_W-1:0]               i_row,
   input  logic [COORD_W-1:0]               i_col,
   input  logic [4*NUM_PLAYERS-1:0]         i_dir_in,
   output logic [COORD_W*NUM_PLAYERS-1:0]   o_pos_x,
   output logic [COORD_W*NUM_PLAYERS-1:0]   o_pos_y,
   output logic [NUM_PLAYERS-1:0]           o_alive,
   output logic                             o_tick,
   output logic                             o_round_over,
   output logic [$clog2(NUM_PLAYERS)-1:0]   o_winner,
   output logic                             o_draw,
   output logic [7:0]                       o_red,
   output logic [7:0]                       o_green,
   output logic [7:0]                       o_blue
);

   localparam int WIN_W = $clog2(NUM_PLAYERS);
   localparam int FC_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int XW    = COORD_W + 1;

   state_t                r_state;
   logic [FC_W-1:0]       r_fcnt;
   logic [COORD_W-1:0]    r_x [NUM_PLAYERS];
   logic [COORD_W-1:0]    r_y [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] r_alive;
   logic                  r_round_over;
   logic [WIN_W-1:0]      r_winner;
   logic                  r_draw;
   logic [23:0]           r_rgb;

   logic                  w_clear;
   logic                  w_run;
   logic                  w_frame_end;
   logic                  w_update;
   logic [COORD_W-1:0]    w_nx [NUM_PLAYERS];
   logic [COORD_W-1:0]    w_ny [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] w_ekill;
   logic [NUM_PLAYERS-1:0] w_hit;
   logic [NUM_PLAYERS-1:0] w_new_alive;
   int                    w_survivors;
   logic [WIN_W-1:0]      w_win;
   logic [23:0]           w_pix;

   function automatic logic spans_overlap(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
      return ({1'b0, a} < {1'b0, b} + XW'(PLAYER_SIZE)) && ({1'b0, b} < {1'b0, a} + XW'(PLAYER_SIZE));
   endfunction

   function automatic logic covers(input logic [COORD_W-1:0] origin, input logic [COORD_W-1:0] scan);
      return ({1'b0, scan} >= {1'b0, origin}) && ({1'b0, scan} < {1'b0, origin} + XW'(PLAYER_SIZE));
   endfunction

   assign w_clear     = reset | i_dflt;
   assign w_run       = (r_state == RUN);
   assign w_frame_end = (i_row == COORD_W'(V_RES - 1)) && (i_col == COORD_W'(H_RES - 1));
   // A restart arriving on an update cycle wins, so no tick is emitted for it.
   assign w_update    = w_frame_end && (r_fcnt == FC_W'(FRAME_DIV - 1)) && w_run && !w_clear;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fcnt <= '0;
      end else if (w_frame_end) begin
         if (r_fcnt == FC_W'(FRAME_DIV - 1)) r_fcnt <= '0;
         else                                r_fcnt <= r_fcnt + 1'b1;
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      tron_motion_unit #(
         .COORD_W     (COORD_W),
         .H_RES       (H_RES),
         .V_RES       (V_RES),
         .PLAYER_SIZE (PLAYER_SIZE),
         .STEP        (STEP),
         .EDGE_MODE   (EDGE_MODE)
      ) u_motion (
         .clock       (clock),
         .i_clear     (w_clear),
         .i_run       (w_run),
         .i_dir       (i_dir_in[4*p +: 4]),
         .i_x         (r_x[p]),
         .i_y         (r_y[p]),
         .o_next_x    (w_nx[p]),
         .o_next_y    (w_ny[p]),
         .o_edge_kill (w_ekill[p])
      );
      assign o_pos_x[p*COORD_W +: COORD_W] = r_x[p];
      assign o_pos_y[p*COORD_W +: COORD_W] = r_y[p];
   end

   // Collisions use candidate positions; an edge-killed player sits at its held position.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         for (int j = i + 1; j < NUM_PLAYERS; j++) begin
            if (r_alive[i] && r_alive[j] &&
                spans_overlap(w_nx[i], w_nx[j]) && spans_overlap(w_ny[i], w_ny[j])) begin
               w_hit[i] = 1'b1;
               w_hit[j] = 1'b1;
            end
         end
      end
   end

   assign w_new_alive = r_alive & ~w_ekill & ~w_hit;

   always_comb begin
      w_survivors = 0;
      w_win       = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (w_new_alive[p]) begin
            w_survivors = w_survivors + 1;
            w_win       = WIN_W'(p);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_clear) begin
         r_state      <= IDLE;
         r_alive      <= '1;
         r_round_over <= 1'b0;
         r_winner     <= '0;
         r_draw       <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            r_x[p] <= START_X[p*COORD_W +: COORD_W];
            r_y[p] <= START_Y[p*COORD_W +: COORD_W];
         end
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) r_state <= RUN;
            end
            RUN: begin
               if (w_update) begin
                  for (int p = 0; p < NUM_PLAYERS; p++) begin
                     if (w_new_alive[p]) begin
                        r_x[p] <= w_nx[p];
                        r_y[p] <= w_ny[p];
                     end
                  end
                  r_alive <= w_new_alive;
                  if (w_survivors <= 1) begin
                     r_state      <= OVER;
                     r_round_over <= 1'b1;
                     r_draw       <= (w_survivors == 0);
                     r_winner     <= w_win;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Descending scan so the lowest-index player covering the pixel is the one kept.
   always_comb begin
      w_pix = '0;
      for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
         if (r_alive[p] && covers(r_x[p], i_col) && covers(r_y[p], i_row)) begin
            w_pix = PLAYER_RGB[p];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_clear) r_rgb <= '0;
      else         r_rgb <= w_pix;
   end

   assign o_alive      = r_alive;
   assign o_tick       = w_update;
   assign o_round_over = r_round_over;
   assign o_winner     = r_winner;
   assign o_draw       = r_draw;
   assign o_red        = r_rgb[23:16];
   assign o_green      = r_rgb[15:8];
   assign o_blue       = r_rgb[7:0];

endmodule
